// File: rtl/pause_pkg.sv
// Shared types and constants for the pause overlay and HUD glyph helpers.
// Holds the pause FSM states, the default glyph colour and the colour-field layout used for dimming.
package pause_pkg;

  typedef enum logic [1:0] {
    RUN,
    ENTER_WAIT,
    PAUSED,
    EXIT_WAIT
  } pause_state_e;

  localparam int          RGB_W        = 5;
  localparam logic [4:0]  DEF_FG_COLOR = 5'b10101;
  localparam logic [4:0]  DEF_BLACK    = 5'b00000;

  localparam int R_MSB = 4;
  localparam int R_LSB = 3;
  localparam int G_MSB = 2;
  localparam int G_LSB = 1;
  localparam int B_MSB = 0;
  localparam int B_LSB = 0;

  // Halve each colour field independently so no bit leaks between fields.
  function automatic logic [RGB_W-1:0] dim_rgb5(input logic [RGB_W-1:0] c);
    logic [RGB_W-1:0] d;
    d = '0;
    d[R_MSB:R_LSB] = c[R_MSB:R_LSB] >> 1;
    d[G_MSB:G_LSB] = c[G_MSB:G_LSB] >> 1;
    d[B_MSB:B_LSB] = c[B_MSB:B_LSB] >> 1;
    return d;
  endfunction

endpackage

// File: rtl/pause_bar_hit.sv
// Combinational hit test for a row of equal vertical bars.
// All comparisons are 12-bit unsigned so right-edge arithmetic cannot wrap.
module pause_bar_hit #(
  parameter int NUM_BARS  = 2,
  parameter int BAR_W     = 16,
  parameter int BAR_PITCH = 64,
  parameter int BAR_H     = 80,
  parameter int X0        = 280,
  parameter int Y0        = 200
) (
  input  logic [10:0] pixel_x_i,
  input  logic [10:0] pixel_y_i,
  output logic        hit_o
);

  localparam logic [11:0] Y_TOP = 12'(Y0);
  localparam logic [11:0] Y_BOT = 12'(Y0 + BAR_H);

  logic [11:0]         x12;
  logic [11:0]         y12;
  logic                y_in;
  logic [NUM_BARS-1:0] bar_hit;

  assign x12  = {1'b0, pixel_x_i};
  assign y12  = {1'b0, pixel_y_i};
  assign y_in = (y12 >= Y_TOP) && (y12 < Y_BOT);

  for (genvar i = 0; i < NUM_BARS; i++) begin : g_bar
    localparam logic [11:0] XL = 12'(X0 + i * BAR_PITCH);
    localparam logic [11:0] XR = 12'(X0 + i * BAR_PITCH + BAR_W);
    assign bar_hit[i] = (x12 >= XL) && (x12 < XR);
  end

  assign hit_o = y_in && (|bar_hit);

endmodule

// File: rtl/pause_overlay.sv
// Pause state owner and blinking N-bar pause glyph overlay on the game pixel stream.
// Optional macro PAUSE_DIM_EN dims the game picture while paused.
module pause_overlay
  import pause_pkg::*;
#(
  parameter int             CW        = 5,
  parameter logic [CW-1:0]  FG_COLOR  = CW'(DEF_FG_COLOR),
  parameter int             NUM_BARS  = 2,
  parameter int             BAR_W     = 16,
  parameter int             BAR_PITCH = 64,
  parameter int             BAR_H     = 80,
  parameter int             X0        = 280,
  parameter int             Y0        = 200,
  parameter int             BLINK_ON  = 30,
  parameter int             BLINK_OFF = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          video_on,
  input  logic [10:0]   pixel_x,
  input  logic [10:0]   pixel_y,
  input  logic          frame_tick,
  input  logic          pause_btn,
  input  logic [CW-1:0] game_rgb,
  output logic          pause_active,
  output logic [CW-1:0] vga_rgb
);

  localparam int BMAX  = (BLINK_ON > BLINK_OFF) ? BLINK_ON : BLINK_OFF;
  localparam int CNT_W = (BMAX < 1) ? 1 : $clog2(BMAX + 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'((BLINK_ON  > 0) ? BLINK_ON  - 1 : 0);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'((BLINK_OFF > 0) ? BLINK_OFF - 1 : 0);

  pause_state_e   state_q;
  logic           req_q;
  logic           pause_q;
  logic           phase_on_q;
  logic           phase_on_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CW-1:0]  rgb_q;
  logic [CW-1:0]  rgb_d;
  logic [CW-1:0]  off_rgb;
  logic           hit;

  pause_bar_hit #(
    .NUM_BARS  (NUM_BARS),
    .BAR_W     (BAR_W),
    .BAR_PITCH (BAR_PITCH),
    .BAR_H     (BAR_H),
    .X0        (X0),
    .Y0        (Y0)
  ) u_hit (
    .pixel_x_i (pixel_x),
    .pixel_y_i (pixel_y),
    .hit_o     (hit)
  );

  // Next blink position for one frame tick; OFF length 0 pins the phase to ON.
  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    phase_on_d = phase_on_q;
    if (phase_on_q) begin
      if (cnt_q == ON_LAST) begin
        cnt_d = '0;
        if (BLINK_OFF != 0) phase_on_d = 1'b0;
      end
    end else if (cnt_q == OFF_LAST) begin
      cnt_d      = '0;
      phase_on_d = 1'b1;
    end
  end

  // Pause FSM, request latch and blink state; button pulses during a pending
  // frame-boundary wait are dropped so one frame never toggles twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      req_q      <= 1'b0;
      pause_q    <= 1'b0;
      cnt_q      <= '0;
      phase_on_q <= 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (req_q) begin
            state_q <= ENTER_WAIT;
            req_q   <= 1'b0;
          end else if (pause_btn) begin
            req_q <= 1'b1;
          end
        end
        ENTER_WAIT: begin
          if (frame_tick) begin
            state_q    <= PAUSED;
            pause_q    <= 1'b1;
            cnt_q      <= '0;
            phase_on_q <= 1'b1;
          end
        end
        PAUSED: begin
          if (req_q) begin
            state_q <= EXIT_WAIT;
            req_q   <= 1'b0;
          end else if (pause_btn) begin
            req_q <= 1'b1;
          end
          if (frame_tick) begin
            cnt_q      <= cnt_d;
            phase_on_q <= phase_on_d;
          end
        end
        EXIT_WAIT: begin
          if (frame_tick) begin
            state_q    <= RUN;
            pause_q    <= 1'b0;
            cnt_q      <= '0;
            phase_on_q <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef PAUSE_DIM_EN
  if (CW == RGB_W) begin : g_dim5
    assign off_rgb = pause_q ? CW'(dim_rgb5(RGB_W'(game_rgb))) : game_rgb;
  end else begin : g_dimn
    assign off_rgb = pause_q ? (game_rgb >> 1) : game_rgb;
  end
`else
  assign off_rgb = game_rgb;
`endif

  // Pixel selection: blanking first, then the glyph, then the game picture.
  always_comb begin
    rgb_d = '0;
    if (!video_on)                         rgb_d = '0;
    else if (pause_q && phase_on_q && hit) rgb_d = FG_COLOR;
    else                                   rgb_d = off_rgb;
  end

  // Register the composited pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign pause_active = pause_q;
  assign vga_rgb      = rgb_q;

endmodule

// File: tb/tb_pause_overlay.sv
// Directed bench for pause_overlay with 3 bars and a 2-on/1-off blink.
// Expected values are hand-computed constants checked with immediate assertions.
module tb_pause_overlay;

  localparam logic [4:0] FG   = 5'b10101;
  localparam logic [4:0] GAME = 5'b00110;
  localparam logic [4:0] WHT  = 5'b11111;
`ifdef PAUSE_DIM_EN
  localparam logic [4:0] WHT_PAUSED  = 5'b01010;
  localparam logic [4:0] GAME_PAUSED = 5'b00010;
`else
  localparam logic [4:0] WHT_PAUSED  = 5'b11111;
  localparam logic [4:0] GAME_PAUSED = 5'b00110;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        frame_tick;
  logic        pause_btn;
  logic [4:0]  game_rgb;
  logic        pause_active;
  logic [4:0]  vga_rgb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pause_overlay #(
    .CW        (5),
    .FG_COLOR  (5'b10101),
    .NUM_BARS  (3),
    .BAR_W     (16),
    .BAR_PITCH (64),
    .BAR_H     (80),
    .X0        (280),
    .Y0        (200),
    .BLINK_ON  (2),
    .BLINK_OFF (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .video_on     (video_on),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .frame_tick   (frame_tick),
    .pause_btn    (pause_btn),
    .game_rgb     (game_rgb),
    .pause_active (pause_active),
    .vga_rgb      (vga_rgb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic btn();
    pause_btn = 1'b1;
    step();
    pause_btn = 1'b0;
  endtask

  task automatic pix(input int x, input int y);
    pixel_x = 11'(x);
    pixel_y = 11'(y);
    step();
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    video_on   = 1'b1;
    pixel_x    = 11'd0;
    pixel_y    = 11'd0;
    frame_tick = 1'b0;
    pause_btn  = 1'b0;
    game_rgb   = GAME;
    step();
    step();
    check("rst_pa",  32'(pause_active), 32'd0);
    check("rst_rgb", 32'(vga_rgb), 32'd0);
    reset = 1'b0;

    step();
    check("run_pass", 32'(vga_rgb), 32'(GAME));

    tick(); step(); step();
    tick(); step(); step();
    tick(); step();
    pixel_x = 11'd100;
    pixel_y = 11'd50;
    btn();
    step(); step(); step();
    check("wait_no_pa", 32'(pause_active), 32'd0);
    pix(285, 210);
    check("run_glyph_pass", 32'(vga_rgb), 32'(GAME));
    tick();
    check("pa_rise", 32'(pause_active), 32'd1);

    step();
    check("blink_on1", 32'(vga_rgb), 32'(FG));
    tick(); step();
    check("blink_on2", 32'(vga_rgb), 32'(FG));
    tick(); step();
    check("blink_off", 32'(vga_rgb), 32'(GAME_PAUSED));
    tick(); step();
    check("blink_on3", 32'(vga_rgb), 32'(FG));

    pix(408, 210);
    check("bar2_left", 32'(vga_rgb), 32'(FG));
    pix(423, 210);
    check("bar2_last", 32'(vga_rgb), 32'(FG));
    pix(424, 210);
    check("bar2_out", 32'(vga_rgb), 32'(GAME_PAUSED));
    pix(407, 210);
    check("gap_407", 32'(vga_rgb), 32'(GAME_PAUSED));
    pix(359, 210);
    check("bar1_last", 32'(vga_rgb), 32'(FG));
    pix(408, 280);
    check("y_bot_out", 32'(vga_rgb), 32'(GAME_PAUSED));
    pix(408, 279);
    check("y_bot_in", 32'(vga_rgb), 32'(FG));
    pix(408, 199);
    check("y_top_out", 32'(vga_rgb), 32'(GAME_PAUSED));
    pix(2047, 210);
    check("x_max", 32'(vga_rgb), 32'(GAME_PAUSED));

    video_on = 1'b0;
    pix(285, 210);
    check("blank", 32'(vga_rgb), 32'd0);
    video_on = 1'b1;
    game_rgb = WHT;
    pix(0, 0);
    check("off_glyph", 32'(vga_rgb), 32'(WHT_PAUSED));
    game_rgb = GAME;

    btn();
    step(); step();
    check("exit_wait_pa", 32'(pause_active), 32'd1);
    tick();
    check("pa_fall", 32'(pause_active), 32'd0);
    pix(285, 210);
    check("run_after_exit", 32'(vga_rgb), 32'(GAME));

    btn();
    step(); step();
    btn();
    step();
    tick();
    check("double_enter", 32'(pause_active), 32'd1);
    step();
    tick(); step();
    tick(); step();
    check("no_double_toggle", 32'(pause_active), 32'd1);

    pause_btn = 1'b1;
    step();
    pause_btn = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_pa",  32'(pause_active), 32'd0);
    check("rst_mid_rgb", 32'(vga_rgb), 32'd0);
    step();
    reset = 1'b0;
    step();
    tick(); step();
    check("req_lost", 32'(pause_active), 32'd0);

    pause_btn  = 1'b1;
    frame_tick = 1'b1;
    step();
    pause_btn  = 1'b0;
    frame_tick = 1'b0;
    step(); step();
    check("simul_wait", 32'(pause_active), 32'd0);
    tick();
    check("simul_enter", 32'(pause_active), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
